// File: rtl/bch_msg_sink_if.sv
`default_nettype none
// ============================================================================
// Module   : bch_msg_sink_if
// Brief    : Decoder-result input and message-result output handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface bch_msg_sink_if;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_codeword;
    logic        in_error_flag;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_msg;
    logic        out_corrected;
    logic        out_uncorrectable;

    modport master (
        output in_valid, in_codeword, in_error_flag, out_ready,
        input  in_ready, out_valid, out_msg, out_corrected, out_uncorrectable
    );

    modport slave (
        input  in_valid, in_codeword, in_error_flag, out_ready,
        output in_ready, out_valid, out_msg, out_corrected, out_uncorrectable
    );
endinterface
`default_nettype wire

// File: rtl/bch_msg_sink.sv
`default_nettype none
// ============================================================================
// Module   : bch_msg_sink
// Brief    : BCH(15,7) residual re-check, message FIFO and saturating stats.
// Revision : 1.0 - initial release
// ============================================================================
module bch_msg_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  wire              clk,
    input  wire              rst,
    bch_msg_sink_if.slave    bus,
    input  wire              clear_stats,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] fail_cnt
);
    localparam int               c_aw      = $clog2(FIFO_DEPTH);
    localparam logic [8:0]       c_gen     = 9'h1D1;
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [8:0]       r_mem [FIFO_DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [6:0]       r_out_msg;
    logic             r_out_corr;
    logic             r_out_unc;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_fail_cnt;

    logic [14:0]      w_rem;
    logic             w_unc;
    logic             w_corr;
    logic [8:0]       w_entry;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [c_aw:0]    w_wr_next;
    logic [c_aw:0]    w_rd_next;
    logic [8:0]       w_head_next;

    // Long division of c(x) by g(x); only the low 8 bits survive as remainder.
    always_comb begin
        w_rem = bus.in_codeword;
        for (int i = 14; i >= 8; i--) begin
            if (w_rem[i]) begin
                w_rem = w_rem ^ (15'(c_gen) << (i - 8));
            end
        end
    end

    assign w_unc   = |w_rem[7:0];
    assign w_corr  = bus.in_error_flag & ~w_unc;
    assign w_entry = {bus.in_codeword[14:8], w_corr, w_unc};

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                       (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    assign w_push    = bus.in_valid & ~w_full;
    assign w_pop     = bus.out_ready & ~w_empty;
    assign w_wr_next = r_wr_ptr + {{c_aw{1'b0}}, w_push};
    assign w_rd_next = r_rd_ptr + {{c_aw{1'b0}}, w_pop};

    // The head register must pick up the entry being written when the new
    // read pointer lands on the slot that is only now being filled.
    assign w_head_next = (w_rd_next == r_wr_ptr) ? w_entry
                                                 : r_mem[w_rd_next[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= w_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_out_msg  <= '0;
            r_out_corr <= 1'b0;
            r_out_unc  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            if (w_rd_next != w_wr_next) begin
                r_out_msg  <= w_head_next[8:2];
                r_out_corr <= w_head_next[1];
                r_out_unc  <= w_head_next[0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
            r_corr_cnt  <= '0;
            r_fail_cnt  <= '0;
        end else if (clear_stats) begin
            r_frame_cnt <= '0;
            r_corr_cnt  <= '0;
            r_fail_cnt  <= '0;
        end else if (w_push) begin
            if (r_frame_cnt != c_cnt_max) r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_corr && (r_corr_cnt != c_cnt_max)) r_corr_cnt <= r_corr_cnt + 1'b1;
            if (w_unc && (r_fail_cnt != c_cnt_max)) r_fail_cnt <= r_fail_cnt + 1'b1;
        end
    end

    assign bus.in_ready          = ~w_full;
    assign bus.out_valid         = ~w_empty;
    assign bus.out_msg           = r_out_msg;
    assign bus.out_corrected     = r_out_corr;
    assign bus.out_uncorrectable = r_out_unc;
    assign frame_cnt             = r_frame_cnt;
    assign corr_cnt              = r_corr_cnt;
    assign fail_cnt              = r_fail_cnt;
endmodule
`default_nettype wire

// File: tb/tb_bch_msg_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_msg_sink
// Brief    : Randomized and directed checks of bch_msg_sink against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bch_msg_sink;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          clear_stats = 1'b0;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] corr_cnt;
    logic [CW-1:0] fail_cnt;

    bch_msg_sink_if bus ();

    bch_msg_sink #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .clear_stats (clear_stats),
        .frame_cnt   (frame_cnt),
        .corr_cnt    (corr_cnt),
        .fail_cnt    (fail_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Code membership: a codeword is valid exactly when it is a multiple of g(x).
    bit          valid_cw [32768];
    logic [14:0] enc [128];

    logic [8:0] q[$];
    int  m_frame, m_corr, m_fail;
    bit  m_acc;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int clmul(input int a, input int b);
        int r = 0;
        for (int i = 0; i < 7; i++) if ((a >> i) & 1) r ^= (b << i);
        return r;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic model_step();
        bit unc, corr, pop;
        m_acc = bus.in_valid && (q.size() < DEPTH);
        pop   = bus.out_ready && (q.size() > 0);
        unc   = !valid_cw[bus.in_codeword];
        corr  = bus.in_error_flag && !unc;
        if (pop) void'(q.pop_front());
        if (m_acc) q.push_back({bus.in_codeword[14:8], corr, unc});
        if (clear_stats) begin
            m_frame = 0; m_corr = 0; m_fail = 0;
        end else if (m_acc) begin
            m_frame = sat_inc(m_frame);
            if (corr) m_corr = sat_inc(m_corr);
            if (unc)  m_fail = sat_inc(m_fail);
        end
    endtask

    task automatic compare_all();
        check("in_ready", bus.in_ready, q.size() < DEPTH);
        check("out_valid", bus.out_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("out_msg", bus.out_msg, q[0][8:2]);
            check("out_corrected", bus.out_corrected, q[0][1]);
            check("out_uncorrectable", bus.out_uncorrectable, q[0][0]);
        end
        check("frame_cnt", frame_cnt, m_frame);
        check("corr_cnt", corr_cnt, m_corr);
        check("fail_cnt", fail_cnt, m_fail);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic v, input logic [14:0] cw, input logic ef,
                         input logic ordy, input logic clr);
        bus.in_valid      = v;
        bus.in_codeword   = cw;
        bus.in_error_flag = ef;
        bus.out_ready     = ordy;
        clear_stats       = clr;
    endtask

    task automatic push_hold(input logic [14:0] cw, input logic ef, input logic ordy);
        int k = 0;
        drive(1'b1, cw, ef, ordy, 1'b0);
        do begin
            cycle();
            k++;
        end while (!m_acc && k < 20);
        if (!m_acc) check("push_timeout", 0, 1);
        drive(1'b0, cw, ef, ordy, 1'b0);
    endtask

    task automatic drain_count(output int n);
        n = 0;
        drive(1'b0, 15'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (bus.out_valid) n++;
            cycle();
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_msg"}, bus.out_msg, 0);
        check({tag, "_out_corr"}, bus.out_corrected, 0);
        check({tag, "_out_unc"}, bus.out_uncorrectable, 0);
        check({tag, "_frame_cnt"}, frame_cnt, 0);
        check({tag, "_corr_cnt"}, corr_cnt, 0);
        check({tag, "_fail_cnt"}, fail_cnt, 0);
    endtask

    initial begin
        int c, nxt, n, bias;
        logic [14:0] cw;
        logic        ef, hold;

        for (int m = 0; m < 128; m++) begin
            c = clmul(m, 'h1D1);
            valid_cw[c] = 1'b1;
            enc[c >> 8] = 15'(c);
        end
        m_frame = 0; m_corr = 0; m_fail = 0;
        drive(1'b0, 15'h0, 1'b0, 1'b0, 1'b0);

        #1;
        check_reset_state("por");
        @(negedge clk);
        rst = 1'b1;

        // Clean, corrected and failed frames back to back.
        drive(1'b1, 15'h01D1, 1'b0, 1'b1, 1'b0);
        cycle();
        check("clean_valid", bus.out_valid, 1);
        check("clean_msg", bus.out_msg, 1);
        check("clean_corr", bus.out_corrected, 0);
        check("clean_unc", bus.out_uncorrectable, 0);
        check("clean_frame_cnt", frame_cnt, 1);
        drive(1'b1, 15'h01D1, 1'b1, 1'b1, 1'b0);
        cycle();
        check("corr_flag", bus.out_corrected, 1);
        check("corr_cnt1", corr_cnt, 1);
        drive(1'b1, 15'h01D0, 1'b0, 1'b1, 1'b0);
        cycle();
        check("fail_unc", bus.out_uncorrectable, 1);
        check("fail_corr", bus.out_corrected, 0);
        check("fail_msg", bus.out_msg, 1);
        check("fail_cnt1", fail_cnt, 1);
        drive(1'b0, 15'h0, 1'b0, 1'b1, 1'b0);
        cycle();

        // Backpressure: five frames into a four-entry FIFO.
        for (int m = 1; m <= 4; m++) push_hold(enc[m], 1'b0, 1'b0);
        check("bp_full", bus.in_ready, 0);
        drive(1'b1, enc[5], 1'b0, 1'b0, 1'b0);
        cycle();
        check("bp_held", bus.in_ready, 0);
        drive(1'b1, enc[5], 1'b0, 1'b1, 1'b0);
        nxt = 1;
        for (int i = 0; i < 12; i++) begin
            if (bus.out_valid && bus.out_ready) begin
                check("bp_order", bus.out_msg, nxt);
                nxt++;
            end
            cycle();
            if (m_acc) bus.in_valid = 1'b0;
        end
        check("bp_drain_count", nxt, 6);

        // Push and pop together with two entries queued.
        push_hold(enc[9], 1'b1, 1'b0);
        push_hold(enc[10], 1'b0, 1'b0);
        drive(1'b1, enc[11], 1'b0, 1'b1, 1'b0);
        cycle();
        check("sim_head", bus.out_msg, 10);
        drain_count(n);
        check("sim_occupancy", n, 2);

        // Clear overrides an increment on the same edge.
        drive(1'b1, 15'h01D0, 1'b1, 1'b1, 1'b1);
        cycle();
        check("clr_frame", frame_cnt, 0);
        check("clr_fail", fail_cnt, 0);
        check("clr_fifo_kept", bus.out_valid, 1);

        // Saturation at 2^CW-1.
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, enc[i], 1'b1, 1'b1, 1'b0);
            cycle();
        end
        check("sat_frame", frame_cnt, SAT);
        drive(1'b0, 15'h0, 1'b0, 1'b1, 1'b0);
        cycle();

        // Three complete fill/drain rounds wrap both pointers.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < DEPTH; k++) push_hold(enc[$urandom_range(127)], 1'(k & 1), 1'b0);
            check("wrap_full", bus.in_ready, 0);
            drain_count(n);
            check("wrap_count", n, DEPTH);
        end

        // Randomized traffic with a holding upstream.
        bias = 50;
        hold = 1'b0;
        cw = 15'h0;
        ef = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (i % 50 == 0) bias = $urandom_range(100);
            if (!hold) begin
                cw = ($urandom % 2 == 0) ? enc[$urandom_range(127)] : 15'($urandom);
                ef = 1'($urandom);
                bus.in_valid = ($urandom % 4) != 0;
            end
            drive(bus.in_valid, cw, ef, ($urandom % 100) < bias, ($urandom % 32) == 0);
            cycle();
            hold = bus.in_valid && !m_acc;
        end

        // Asynchronous reset mid-stream with three entries queued.
        drive(1'b0, 15'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        for (int k = 0; k < 3; k++) push_hold(enc[20 + k], 1'b1, 1'b0);
        check("pre_rst_valid", bus.out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_state("mid");
        q.delete();
        m_frame = 0; m_corr = 0; m_fail = 0;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 15'h0, 1'b0, 1'b0, 1'b0);
        cycle();
        check("post_rst_empty", bus.out_valid, 0);
        drive(1'b1, enc[33], 1'b0, 1'b1, 1'b0);
        cycle();
        check("post_rst_msg", bus.out_msg, 33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bch_msg_sink.md
# bch_msg_sink

Receive-side stage placed directly downstream of the BCH(15,7) decoder. Accepts each corrected 15-bit codeword with the decoder's error flag and re-checks it against the generator polynomial to detect decoding failures. Extracts the 7-bit message and buffers results in a small FIFO behind a valid/ready output. Keeps saturating frame, corrected and failure statistics.

## Interface
- FIFO_DEPTH, 4, result FIFO entries; power of two, ≥2
- CNT_W, 16, width of each statistics counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  decoder result present
- in_ready  out  1  sink can accept; equals !full
- in_codeword  in  15  corrected codeword, systematic {msg[6:0], parity[7:0]}, message in bits 14:8
- in_error_flag  in  1  decoder located and corrected ≥1 error
- out_valid  out  1  FIFO head valid; equals !empty
- out_ready  in  1  consumer takes head
- out_msg  out  7  message of head entry
- out_corrected  out  1  head frame was corrected by decoder
- out_uncorrectable  out  1  head frame fails residual check
- clear_stats  in  1  synchronous clear of all counters
- frame_cnt  out  CNT_W  frames accepted
- corr_cnt  out  CNT_W  frames accepted with in_error_flag=1 and residual zero
- fail_cnt  out  CNT_W  frames accepted with residual nonzero

## Operation
- Accept occurs when in_valid && in_ready; nothing is sampled otherwise.
- Residual check is combinational on in_codeword: remainder of c(x) mod g(x), with g(x)=x^8+x^7+x^6+x^4+1 (0x1D1) and bit 14 = x^14.
- A nonzero remainder sets uncorrectable=1.
- corrected = in_error_flag && !uncorrectable.
- The FIFO entry written on accept is {in_codeword[14:8], corrected, uncorrectable}: 9 bits.
- FIFO is a circular buffer.
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits, using the extra-MSB full/empty scheme.
  - Pointers wrap from FIFO_DEPTH-1 to 0.
- Pop occurs when out_valid && out_ready.
- Simultaneous push and pop:
  - Not full and not empty: both occur, occupancy unchanged.
  - Empty: push only. No same-cycle bypass.
  - Full: in_ready=0, so pop only.
- Outputs out_msg, out_corrected and out_uncorrectable present the head entry.
  - While out_valid=0 they hold their last values (all 0 after reset).
  - They are don't-care for checking.
- Counter updates, on accept:
  - frame_cnt +1 on every accept.
  - corr_cnt +1 if corrected.
  - fail_cnt +1 if uncorrectable.
  - All counters saturate at 2^CNT_W-1 and do not wrap.
- clear_stats=1 zeroes all counters on the next edge and overrides any increment in the same cycle.
  - The FIFO is unaffected by clear_stats.
- Reset (rst=0), asynchronous, including mid-operation:
  - Pointers are 0: FIFO empty, stored entries discarded.
  - out_valid=0, in_ready=1.
  - out_msg=0, out_corrected=0, out_uncorrectable=0.
  - All counters are 0.

## Timing
- Latency: a frame accepted at edge N appears at the FIFO head with out_valid=1 after edge N, i.e. in cycle N+1, if the FIFO was empty.
- Counters reflect an accept after the same edge N.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready.
- Throughput: one accept and one pop per cycle sustained.
- Full: after FIFO_DEPTH accepts with no pops, in_ready=0. It returns to 1 in the cycle after the first pop edge.
- Upstream must hold in_codeword and in_error_flag stable while in_valid=1 && in_ready=0.
- Downstream sees head data stable while out_valid=1 && out_ready=0.
- The first edge after rst deasserts can accept a frame.

## Test plan
- Reset: drive rst=0 mid-stream with 3 entries queued.
  - Required: out_valid=0, in_ready=1 and all counters 0 immediately, without waiting for a clock edge.
  - After release, empty FIFO.
- Clean frame: in_codeword=0x01D1, in_error_flag=0, out_ready=1.
  - Next cycle: out_valid=1, out_msg=0x01, out_corrected=0, out_uncorrectable=0.
  - frame_cnt=1, corr_cnt=0, fail_cnt=0.
- Corrected and failed frames:
  - 0x01D1 with in_error_flag=1 → out_corrected=1, corr_cnt=1.
  - 0x01D0 (residual nonzero) → out_uncorrectable=1, out_corrected=0, fail_cnt=1, out_msg=0x01.
- Backpressure: out_ready=0, push 5 frames with msgs 1..5.
  - in_ready drops after the 4th accept; frame 5 is held.
  - Raise out_ready: outputs appear in order 1,2,3,4,5 with no loss or duplication.
- Simultaneous events:
  - With 2 entries queued, push and pop in the same cycle → occupancy stays 2 and order is preserved.
  - With clear_stats=1 on an accepting cycle → all counters read 0 afterwards.
- Saturation: CNT_W=4, 17 accepts → frame_cnt stays at 15.
  - Then wrap pointers through 3 full FIFO cycles → data remains intact.
